// File: rtl/sync_up_counter.sv
// Synchronous modulo-MAX up counter with enable prescaler, parallel load,
// clear, combinational carry-out for cascading and a registered wrap pulse.
module sync_up_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 2**WIDTH-1,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             en,
  output logic [WIDTH-1:0] qOut,
  output logic             tc,
  output logic             wrap
);

  localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             wrap_q, wrap_d;
  logic             tick_s;
  logic             at_max_s;

  // Prescaler terminal detect and counter terminal detect
  always_comb begin
    tick_s   = en & (pre_q == PRE_LAST);
    at_max_s = (cnt_q == MAX_V);
  end

  // Next-state selection: clear, then load, then counting
  always_comb begin
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
      pre_d = '0;
    end else if (load) begin
      cnt_d = (loadVal > MAX_V) ? MAX_V : loadVal;
      pre_d = '0;
    end else if (tick_s) begin
      pre_d = '0;
      if (at_max_s) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else if (en) begin
      pre_d = pre_q + PW'(1);
    end else begin
      pre_d = pre_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      pre_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
    end
  end

  // Carry-out is suppressed whenever a higher-priority event owns the edge
  always_comb begin
    tc = tick_s & at_max_s & rst & ~clr & ~load;
  end

  assign qOut = cnt_q;
  assign wrap = wrap_q;

endmodule
